// File: rtl/smem_output_ctrl.sv
// Drains the SMEM result RAM into the host write path through a small line FIFO.
// It requests the host writer, grants the RAM permission to stream, and throttles the RAM through the stall line.
module smem_output_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pipe_stall_i,
  output logic                 stall_o,
  input  logic                 output_request_i,
  output logic                 output_permit_o,
  input  logic [511:0]         output_data_i,
  input  logic                 output_valid_i,
  input  logic                 output_finish_i,
  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  output logic [511:0]         host_data_o,
  output logic                 host_valid_o,
  input  logic                 host_ready_i,
  output logic                 host_last_o,
  output logic [CNT_WIDTH-1:0] line_count_o,
  output logic                 batch_done_o
);

  // state | meaning
  // IDLE  | waiting for the result RAM to report a complete batch
  // REQ   | requesting the host write path
  // DRAIN | host owned, RAM streaming lines into the FIFO
  // FLUSH | RAM finished, emptying the FIFO to the host
  // DONE  | batch delivered, waiting for the request to drop

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_OCC  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] STALL_OCC = (AW+1)'(FIFO_DEPTH - 2);
  localparam logic [AW:0] ONE_OCC   = (AW+1)'(1);

  typedef enum logic [2:0] {IDLE, REQ, DRAIN, FLUSH, DONE} state_t;

  state_t               state_q, state_d;
  logic [511:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          occ_q;
  logic                 overflow_q;
  logic [CNT_WIDTH-1:0] count_q;

  logic in_xfer, gnt_lost, fifo_empty, fifo_full;
  logic push, push_ok, pop, empty_next;

  assign in_xfer    = (state_q == DRAIN) || (state_q == FLUSH);
  assign gnt_lost   = in_xfer & ~host_gnt_i;
  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == FULL_OCC);

  assign host_valid_o = ~fifo_empty & ~gnt_lost;
  assign pop          = host_valid_o & host_ready_i;
  assign push         = output_valid_i & in_xfer;
  assign push_ok      = push & (~fifo_full | pop);
  assign empty_next   = fifo_empty | ((occ_q == ONE_OCC) & pop & ~push_ok);

  // The threshold leaves one free slot for the line the RAM may launch as it samples stall.
  assign stall_o      = in_xfer ? (gnt_lost | (occ_q >= STALL_OCC)) : pipe_stall_i;
  assign host_data_o  = mem_q[rd_ptr_q];
  assign host_last_o  = (state_q == FLUSH) & (occ_q == ONE_OCC);
  assign line_count_o = count_q;

  always_comb begin
    state_d         = state_q;
    output_permit_o = 1'b0;
    host_req_o      = 1'b0;
    batch_done_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (output_request_i) state_d = REQ;
      end
      REQ: begin
        host_req_o = 1'b1;
        if (host_gnt_i) state_d = DRAIN;
      end
      DRAIN: begin
        host_req_o      = 1'b1;
        output_permit_o = 1'b1;
        if (output_finish_i && host_gnt_i) state_d = FLUSH;
      end
      FLUSH: begin
        host_req_o      = 1'b1;
        output_permit_o = 1'b1;
        if (empty_next && host_gnt_i) state_d = DONE;
      end
      DONE: begin
        batch_done_o = 1'b1;
        if (!output_request_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= output_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (state_q == IDLE && state_d == REQ) begin
      count_q <= '0;
    end else if (pop) begin
      count_q <= count_q + 1'b1;
    end
  end

  // A dropped line means the stall threshold no longer covers the RAM's launch latency.
  no_overflow: assert property (@(posedge clk) disable iff (reset) !overflow_q);

endmodule

// File: tb/tb_smem_output_ctrl.sv
// Directed bench for smem_output_ctrl: a cycle table for the basic handshake plus
// batch sequences with a small RAM model for the multi-cycle corner cases.
module tb_smem_output_ctrl;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_WIDTH  = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 pipe_stall_i, stall_o, output_request_i, output_permit_o;
  logic [511:0]         output_data_i, host_data_o;
  logic                 output_valid_i, output_finish_i, host_req_o, host_gnt_i;
  logic                 host_valid_o, host_ready_i, host_last_o, batch_done_o;
  logic [CNT_WIDTH-1:0] line_count_o;

  int errors = 0;
  int checks = 0;
  int last_n = 0;

  smem_output_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .reset(reset), .pipe_stall_i(pipe_stall_i), .stall_o(stall_o),
    .output_request_i(output_request_i), .output_permit_o(output_permit_o),
    .output_data_i(output_data_i), .output_valid_i(output_valid_i),
    .output_finish_i(output_finish_i), .host_req_o(host_req_o), .host_gnt_i(host_gnt_i),
    .host_data_o(host_data_o), .host_valid_o(host_valid_o), .host_ready_i(host_ready_i),
    .host_last_o(host_last_o), .line_count_o(line_count_o), .batch_done_o(batch_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ps, rq, vl;
    logic [7:0] tag;
    logic       fin, gnt, rdy;
    logic       e_stall, e_permit, e_req, e_valid, e_last, e_done;
    logic [7:0] e_cnt;
    logic [7:0] e_tag;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [511:0] mk_line(input logic [31:0] tag);
    return {16{tag}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_batch(input int n, input int mode, input int gnt_delay, input int hold);
    int sent = 0, got = 0, cyc_n = 0, last_pop = -10, done_at = -1, max_occ = 0;
    bit prev_stall = 0, order_ok = 1, last_ok = 1, stall_ok = 1, timeout = 0;
    bit grant_ok = 1, hold_ok = 1;
    output_request_i = 1; host_gnt_i = 0; output_valid_i = 0; output_finish_i = 0;
    host_ready_i = 0; pipe_stall_i = 0;
    #1;
    check("idle count hold", 64'(line_count_o), 64'(last_n));
    check("idle req low", 64'(host_req_o), 0);
    tick();
    for (int d = 0; d < gnt_delay; d++) begin
      output_valid_i = 1; output_data_i = mk_line(32'hDEAD_0000 + d);
      #1;
      if (output_permit_o !== 1'b0 || host_req_o !== 1'b1) grant_ok = 0;
      tick();
    end
    output_valid_i = 0;
    if (gnt_delay > 0) begin
      check("permit low before grant", 64'(grant_ok), 1);
      check("no push before grant", 64'(dut.occ_q), 0);
    end
    host_gnt_i = 1;
    #1;
    check("req in REQ", 64'(host_req_o), 1);
    check("count cleared on request", 64'(line_count_o), 0);
    check("permit low at grant", 64'(output_permit_o), 0);
    tick();
    check("permit after grant", 64'(output_permit_o), 1);
    while (done_at < 0 && !timeout) begin
      if (mode == 0) host_ready_i = 1;
      else if (mode == 1) host_ready_i = (cyc_n >= 8);
      else host_ready_i = 1'($urandom_range(0, 1));
      if (output_permit_o && !prev_stall && sent < n) begin
        output_valid_i = 1; output_data_i = mk_line(32'(sent + 1)); sent++;
      end else begin
        output_valid_i = 0;
      end
      output_finish_i = (sent == n);
      #1;
      if (output_permit_o && (stall_o !== (int'(dut.occ_q) >= FIFO_DEPTH - 2))) stall_ok = 0;
      if (int'(dut.occ_q) > max_occ) max_occ = int'(dut.occ_q);
      if (host_valid_o && host_ready_i) begin
        got++;
        if (host_data_o !== mk_line(32'(got))) order_ok = 0;
        if (host_last_o !== (got == n)) last_ok = 0;
        last_pop = cyc_n;
      end
      if (batch_done_o) done_at = cyc_n;
      prev_stall = stall_o;
      tick();
      cyc_n++;
      if (cyc_n > 3000) timeout = 1;
    end
    check("batch timeout", 64'(timeout), 0);
    check("lines delivered", 64'(got), 64'(n));
    check("line order", 64'(order_ok), 1);
    check("last only on final line", 64'(last_ok), 1);
    check("line count", 64'(line_count_o), 64'(n));
    check("done one cycle after last pop", 64'(done_at), 64'(last_pop + 1));
    check("stall threshold", 64'(stall_ok), 1);
    check("occupancy bound", 64'(max_occ <= FIFO_DEPTH - 1), 1);
    if (mode == 1) check("occupancy peak under stall", 64'(max_occ), 3);
    check("overflow flag", 64'(dut.overflow_q), 0);
    output_valid_i = 0;
    for (int h = 0; h < hold; h++) begin
      #1;
      if (batch_done_o !== 1'b1 || host_req_o !== 1'b0) hold_ok = 0;
      tick();
    end
    if (hold > 0) check("done held with request", 64'(hold_ok), 1);
    output_request_i = 0; output_finish_i = 0; host_gnt_i = 0; host_ready_i = 0;
    #1;
    check("done until request falls", 64'(batch_done_o), 1);
    tick();
    check("done cleared in idle", 64'(batch_done_o), 0);
    check("count held after batch", 64'(line_count_o), 64'(n));
    last_n = n;
  endtask

  initial begin
    reset = 1; pipe_stall_i = 0; output_request_i = 0; output_data_i = '0;
    output_valid_i = 0; output_finish_i = 0; host_gnt_i = 0; host_ready_i = 0;

    //            ps rq vl tag    fin gnt rdy  st pm rq v  l  d  cnt  etag
    vecs[0]  = '{1, 0, 0, 8'h00, 0,  0,  0,   1, 0, 0, 0, 0, 0, 8'd0, 8'h00};
    vecs[1]  = '{0, 1, 0, 8'h00, 0,  0,  0,   0, 0, 0, 0, 0, 0, 8'd0, 8'h00};
    vecs[2]  = '{0, 1, 0, 8'h00, 0,  0,  0,   0, 0, 1, 0, 0, 0, 8'd0, 8'h00};
    vecs[3]  = '{0, 1, 0, 8'h00, 0,  1,  0,   0, 0, 1, 0, 0, 0, 8'd0, 8'h00};
    vecs[4]  = '{0, 1, 1, 8'hA1, 0,  1,  0,   0, 1, 1, 0, 0, 0, 8'd0, 8'h00};
    vecs[5]  = '{0, 1, 1, 8'hA2, 0,  1,  0,   0, 1, 1, 1, 0, 0, 8'd0, 8'hA1};
    vecs[6]  = '{0, 1, 1, 8'hA3, 0,  1,  0,   1, 1, 1, 1, 0, 0, 8'd0, 8'hA1};
    vecs[7]  = '{0, 1, 0, 8'h00, 0,  1,  1,   1, 1, 1, 1, 0, 0, 8'd0, 8'hA1};
    vecs[8]  = '{0, 1, 0, 8'h00, 0,  0,  1,   1, 1, 1, 0, 0, 0, 8'd1, 8'h00};
    vecs[9]  = '{0, 1, 0, 8'h00, 1,  1,  1,   1, 1, 1, 1, 0, 0, 8'd1, 8'hA2};
    vecs[10] = '{0, 1, 0, 8'h00, 1,  1,  0,   0, 1, 1, 1, 1, 0, 8'd2, 8'hA3};
    vecs[11] = '{0, 1, 0, 8'h00, 1,  1,  1,   0, 1, 1, 1, 1, 0, 8'd2, 8'hA3};
    vecs[12] = '{1, 1, 0, 8'h00, 1,  1,  0,   1, 0, 0, 0, 0, 1, 8'd3, 8'h00};
    vecs[13] = '{0, 0, 0, 8'h00, 0,  0,  0,   0, 0, 0, 0, 0, 1, 8'd3, 8'h00};
    vecs[14] = '{0, 0, 0, 8'h00, 0,  0,  0,   0, 0, 0, 0, 0, 0, 8'd3, 8'h00};
    vecs[15] = '{1, 1, 0, 8'h00, 0,  0,  0,   1, 0, 0, 0, 0, 0, 8'd3, 8'h00};
    vecs[16] = '{1, 1, 0, 8'h00, 0,  0,  0,   1, 0, 1, 0, 0, 0, 8'd0, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    reset = 0;

    for (int i = 0; i < 17; i++) begin
      pipe_stall_i = vecs[i].ps; output_request_i = vecs[i].rq;
      output_valid_i = vecs[i].vl; output_data_i = {64{vecs[i].tag}};
      output_finish_i = vecs[i].fin; host_gnt_i = vecs[i].gnt; host_ready_i = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d stall", i), 64'(stall_o), 64'(vecs[i].e_stall));
      check($sformatf("vec%0d permit", i), 64'(output_permit_o), 64'(vecs[i].e_permit));
      check($sformatf("vec%0d host_req", i), 64'(host_req_o), 64'(vecs[i].e_req));
      check($sformatf("vec%0d host_valid", i), 64'(host_valid_o), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d host_last", i), 64'(host_last_o), 64'(vecs[i].e_last));
      check($sformatf("vec%0d batch_done", i), 64'(batch_done_o), 64'(vecs[i].e_done));
      check($sformatf("vec%0d line_count", i), 64'(line_count_o), 64'(vecs[i].e_cnt));
      if (vecs[i].e_valid)
        check($sformatf("vec%0d host_data", i), 64'(host_data_o[63:0]), 64'({8{vecs[i].e_tag}}));
      tick();
    end

    // Reset mid-DRAIN with three lines buffered; the DUT sits in REQ here.
    pipe_stall_i = 0; output_valid_i = 0; host_gnt_i = 1; host_ready_i = 0;
    tick();
    for (int k = 0; k < 3; k++) begin
      output_valid_i = 1; output_data_i = mk_line(32'h11 + k);
      tick();
    end
    output_valid_i = 0;
    check("occupancy before reset", 64'(dut.occ_q), 3);
    reset = 1; pipe_stall_i = 1;
    for (int r = 0; r < 2; r++) begin
      #1;
      check($sformatf("rst%0d stall", r), 64'(stall_o), 1);
      check($sformatf("rst%0d permit", r), 64'(output_permit_o), 0);
      check($sformatf("rst%0d host_req", r), 64'(host_req_o), 0);
      check($sformatf("rst%0d host_valid", r), 64'(host_valid_o), 0);
      check($sformatf("rst%0d host_last", r), 64'(host_last_o), 0);
      check($sformatf("rst%0d batch_done", r), 64'(batch_done_o), 0);
      check($sformatf("rst%0d line_count", r), 64'(line_count_o), 0);
      check($sformatf("rst%0d host_data", r), 64'(host_data_o != '0), 0);
      check($sformatf("rst%0d occupancy", r), 64'(dut.occ_q), 0);
      check($sformatf("rst%0d state", r), 64'(dut.state_q), 0);
      tick();
    end
    output_request_i = 0; host_gnt_i = 0; pipe_stall_i = 0;
    reset = 0;
    tick();
    last_n = 0;

    run_batch(6, 0, 0, 0);
    run_batch(6, 1, 0, 0);
    run_batch(200, 2, 0, 0);
    run_batch(4, 0, 10, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/smem_output_ctrl.md
# smem_output_ctrl

Controller that sequences the drain of the per-read SMEM result store to the host write path. It waits for the store's output request, obtains the host writer through a req/gnt handshake, and grants output permission. It then buffers the store's 512-bit output lines in a small FIFO and throttles the store through the shared stall line so no line is ever lost. It sits between the SMEM result RAM and the host write-back arbiter, and signals batch completion.

## Interface
- FIFO_DEPTH, 4: output line FIFO entries; power of two, >= 4.
- CNT_WIDTH, 16: width of the emitted-line counter.
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- pipe_stall_i  in  1  pipeline stall from the SMEM datapath.
- stall_o  out  1  stall driven to the result RAM.
- output_request_i  in  1  result RAM has a complete batch.
- output_permit_o  out  1  permission to the result RAM to stream.
- output_data_i  in  512  line from the result RAM.
- output_valid_i  in  1  line valid.
- output_finish_i  in  1  result RAM has emitted its last line (level).
- host_req_o  out  1  request for the host write path.
- host_gnt_i  in  1  host write path granted (level, held while owned).
- host_data_o  out  512  FIFO head.
- host_valid_o  out  1  FIFO non-empty.
- host_ready_i  in  1  host accepts the head this cycle.
- host_last_o  out  1  marks the final line of the batch.
- line_count_o  out  CNT_WIDTH  lines accepted by host this batch.
- batch_done_o  out  1  batch fully delivered.

## Operation
- FSM states: IDLE, REQ, DRAIN, FLUSH, DONE.
  - IDLE: output_request_i=1 -> REQ.
  - REQ: host_req_o=1; host_gnt_i=1 -> DRAIN.
  - DRAIN: host_req_o=1, output_permit_o=1. output_finish_i=1 -> FLUSH.
  - FLUSH: host_req_o=1, output_permit_o=1. Exits to DONE when FIFO empty.
  - DONE: batch_done_o=1 and host_req_o=0. output_request_i=0 -> IDLE.
- output_permit_o is decoded from state and asserted only in DRAIN and FLUSH.
- stall_o = pipe_stall_i in IDLE, REQ and DONE.
- stall_o = (occupancy >= FIFO_DEPTH-2) in DRAIN and FLUSH. This is combinational from the registered occupancy. It leaves room for the one line the RAM may launch in the cycle stall is sampled low.
- FIFO push: output_valid_i=1 in DRAIN or FLUSH. Push is ignored in any other state.
- FIFO pop: host_valid_o & host_ready_i.
- Simultaneous push and pop: occupancy unchanged, and both data paths take effect.
- Occupancy width is log2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.
- A push while the FIFO is full is an overflow. The line is dropped, and a sticky internal overflow flag is set for verification; it is cleared by reset only. By construction this must never occur.
- host_last_o = FLUSH & occupancy==1. The RAM emits no lines once finish is high.
- line_count_o increments on each pop and wraps at 2^CNT_WIDTH. It clears on the IDLE->REQ transition and holds its value through DONE.
- host_gnt_i dropping in DRAIN or FLUSH: host_valid_o is forced to 0 and stall_o is forced to 1 until the grant returns; the state is held.
- Reset, including mid-batch: FSM -> IDLE and FIFO emptied. All outputs go to their reset values; pipe_stall_i passes through.

## Timing
- Reset values:
  - stall_o = pipe_stall_i.
  - output_permit_o, host_req_o, host_valid_o, host_last_o, batch_done_o = 0.
  - line_count_o = 0.
  - host_data_o = 0, since FIFO storage is cleared.
- output_request_i rising -> host_req_o high the next cycle.
- host_gnt_i high -> output_permit_o high one cycle later.
- Line latency from output_valid_i to host_valid_o is 1 cycle; the FIFO is registered with no bypass.
- Throughput is one line per cycle when host_ready_i is held high.
- FIFO empty in FLUSH -> DONE next cycle, so batch_done_o rises one cycle after the last pop.

## Test plan
- Reset mid-DRAIN with 3 lines buffered -> next cycle all outputs at reset values, occupancy 0, state IDLE.
- Batch of 2 reads, each with mem_size=3, host_ready_i held 1. The RAM emits header, 2-mem line, 1-mem line per read, i.e. 6 lines. Required response:
  - host_valid_o high for 6 lines in order.
  - host_last_o only on line 6.
  - line_count_o=6.
  - batch_done_o high after the final pop.
- host_ready_i=0 throughout DRAIN with FIFO_DEPTH=4:
  - stall_o rises when occupancy reaches 2.
  - Occupancy never exceeds 3 and the overflow flag stays 0.
  - Releasing ready drains all lines in order with none lost.
- Random host_ready_i (50%) over 200 lines -> host output is identical to the RAM line sequence and line_count_o=200.
- host_gnt_i delayed 10 cycles after host_req_o -> output_permit_o stays 0 and no push occurs for those 10 cycles. Permit rises 1 cycle after the grant.
- In DONE with output_request_i held at 1 for 5 cycles -> batch_done_o is held for 5 cycles. Return to IDLE occurs the cycle after output_request_i falls, and a new request restarts with line_count_o cleared.
